ne_dot_tree_sched: RTL and testbench

- Time-multiplexes one shared 32-input carry-save reduction tree (sum and carry outputs) between two dot-product requesters.
- Each requester streams a packet of one or more 32-element product beats. The block arbitrates round-robin per packet, drives the tree, resolves sum+carry, and accumulates the beats into one signed result per packet.
- Sits between the PE product generators and the PE result/writeback stage. The tree itself is external and purely combinational.

---
 rtl/ne_dot_tree_sched.sv | 111 +++++++++++
 tb/tb_ne_dot_tree_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ne_dot_tree_sched.sv
// Shares one external 32-input carry-save tree between two requesters, per-packet round-robin, signed dot-product accumulate.
// Latency: one-beat packet returns a result 3 cycles after valid is first seen; k beats with no gaps take 2+k cycles.
// Backpressure: only the granted requester sees ready, and only in ACC; a stalled result holds everything and keeps both readys low.
module ne_dot_tree_sched #(
  parameter int NUM_IN = 32,
  parameter int IN_W   = 15,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [NUM_IN*IN_W-1:0]   req0_data,
  input  logic                     req0_last,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [NUM_IN*IN_W-1:0]   req1_data,
  input  logic                     req1_last,
  output logic [NUM_IN*IN_W-1:0]   tree_in,
  input  logic [IN_W-1:0]          tree_out0,
  input  logic [IN_W-1:0]          tree_out1,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic                     res_id,
  output logic                     res_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, RESULT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic             grant_nxt;
  logic             rr;
  logic             beat_vld;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic             accept0;
  logic             accept1;
  logic             accept_any;
  logic             accept_last;
  logic [IN_W-1:0]  tree_sum;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             ovf_now;

  // Handshake decode, tree resolution and signed overflow detect for the accumulate step.
  always_comb begin
    req0_ready  = (state == ACC) && !grant;
    req1_ready  = (state == ACC) && grant;
    accept0     = req0_ready && req0_valid;
    accept1     = req1_ready && req1_valid;
    accept_any  = accept0 || accept1;
    accept_last = accept1 ? req1_last : req0_last;
    tree_sum    = tree_out0 + tree_out1;
    sum_ext     = {{(ACC_W-IN_W){tree_sum[IN_W-1]}}, tree_sum};
    acc_sum     = acc + sum_ext;
    ovf_now     = (acc[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    res_valid   = (state == RESULT);
    res_data    = res_valid ? acc : '0;
    res_id      = res_valid && grant;
    res_ovf     = res_valid && ovf;
  end

  // Next-state and grant selection; grant only changes in IDLE so it stays locked for the whole packet.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_nxt = (req0_valid && req1_valid) ? rr : req1_valid;
          state_nxt = ACC;
        end
      end
      ACC:     if (accept_any && accept_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand register toward the tree, and the per-packet accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      rr       <= 1'b0;
      beat_vld <= 1'b0;
      tree_in  <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      beat_vld <= accept_any;
      tree_in  <= accept_any ? (accept1 ? req1_data : req0_data) : '0;
      if (res_valid && res_ready) begin
        acc <= '0;
        ovf <= 1'b0;
        rr  <= ~grant;
      end else if (beat_vld) begin
        acc <= acc_sum;
        ovf <= ovf | ovf_now;
      end
    end
  end

endmodule

// File: tb/tb_ne_dot_tree_sched.sv
// Bench for ne_dot_tree_sched with a narrow accumulator so overflow is reachable in a few beats.
// Latency: checks the 2+k result latency on gap-free packets.
// Backpressure: holds res_ready low to check result stability and locked-out readys.
module tb_ne_dot_tree_sched;
  localparam int NUM_IN = 32;
  localparam int IN_W   = 15;
  localparam int ACC_W  = 16;
  localparam int DW     = NUM_IN * IN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req0_ready, req0_last = 1'b0;
  logic             req1_valid = 1'b0, req1_ready, req1_last = 1'b0;
  logic [DW-1:0]    req0_data = '0, req1_data = '0, tree_in;
  logic [IN_W-1:0]  tree_out0, tree_out1, tsum;
  logic             res_valid, res_ready = 1'b0, res_id, res_ovf;
  logic [ACC_W-1:0] res_data;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit block1 = 1'b0;
  int t0;

  ne_dot_tree_sched #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_last(req1_last),
    .tree_in(tree_in), .tree_out0(tree_out0), .tree_out1(tree_out1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: true sum split into an arbitrary carry part and the matching remainder.
  always_comb begin
    tsum = '0;
    for (int i = 0; i < NUM_IN; i++) tsum = tsum + tree_in[i*IN_W +: IN_W];
    tree_out1 = tree_in[IN_W-1:0] ^ 15'h2A5A;
    tree_out0 = tsum - tree_out1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Invariants sampled every cycle away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (block1) chk("req1_locked_out", {31'd0, req1_ready}, 32'd0);
    end
  end

  function automatic logic [DW-1:0] mk(int v, bit single);
    logic [DW-1:0]   d = '0;
    logic [IN_W-1:0] e = v[IN_W-1:0];
    for (int i = 0; i < NUM_IN; i++)
      if (!single || i == 0) d[i*IN_W +: IN_W] = e;
    return d;
  endfunction

  task automatic drive(bit id, logic [DW-1:0] d, bit last, bit vld);
    if (id) begin req1_valid = vld; req1_data = d; req1_last = last; end
    else    begin req0_valid = vld; req0_data = d; req0_last = last; end
  endtask

  // Waits for the requester's ready, then steps past the accepting edge.
  task automatic wait_ready(bit id);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (n >= 20) begin fails++; $display("FAIL ready_timeout: req%0d ready never rose, expected within 20 cycles", id); end
    @(posedge clk); #1;
  endtask

  task automatic send(bit id, int k, int v0, int v1, int v2, bit single, bit gap, bit raise1, output int start);
    int vals[3];
    vals[0] = v0; vals[1] = v1; vals[2] = v2;
    start = cyc;
    for (int b = 0; b < k; b++) begin
      drive(id, mk(vals[b], single), b == k - 1, 1'b1);
      wait_ready(id);
      drive(id, '0, 1'b0, 1'b0);
      if (raise1 && b == 0) begin drive(1'b1, mk(4, 1'b0), 1'b1, 1'b1); block1 = 1'b1; end
      if (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic get_result(bit id, logic [15:0] data, bit ovf, int hold, int start, int lat, string name);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (n >= 40) begin fails++; $display("FAIL %s_timeout: res_valid never rose, expected within 40 cycles", name); end
    if (lat > 0) chk({name, "_latency"}, cyc - start, lat);
    chk({name, "_data"}, {16'd0, res_data}, {16'd0, data});
    chk({name, "_id"}, {31'd0, res_id}, {31'd0, id});
    chk({name, "_ovf"}, {31'd0, res_ovf}, {31'd0, ovf});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_ctl"}, {29'd0, res_valid, req0_ready, req1_ready}, 32'd4);
      chk({name, "_hold_data"}, {15'd0, res_id, res_data}, {15'd0, id, data});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    block1 = 1'b0;
    @(negedge clk);
    chk({name, "_res_drop"}, {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Both requesters present one beat (1s and 4s); the expected winner goes first.
  task automatic pair(bit first);
    drive(1'b0, mk(1, 1'b0), 1'b1, 1'b1);
    drive(1'b1, mk(4, 1'b0), 1'b1, 1'b1);
    wait_ready(first);
    drive(first, '0, 1'b0, 1'b0);
    get_result(first, first ? 16'd128 : 16'd32, 1'b0, 0, 0, 0, "pair_first");
    wait_ready(!first);
    drive(!first, '0, 1'b0, 1'b0);
    get_result(!first, first ? 16'd32 : 16'd128, 1'b0, 0, 0, 0, "pair_second");
  endtask

  typedef struct {
    bit          id;
    int          k;
    int          v[3];
    bit          single;
    logic [15:0] exp;
    bit          ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic addv(int i, bit id, int k, int a, int b, int c, bit s, logic [15:0] e, bit o);
    tbl[i].id = id; tbl[i].k = k; tbl[i].v[0] = a; tbl[i].v[1] = b; tbl[i].v[2] = c;
    tbl[i].single = s; tbl[i].exp = e; tbl[i].ovf = o;
  endtask

  initial begin
    addv(0, 1'b0, 1,      1,      0,  0, 1'b0, 16'h0020, 1'b0);
    addv(1, 1'b1, 3,      2,      3, -1, 1'b0, 16'h0080, 1'b0);
    addv(2, 1'b0, 1,     -1,      0,  0, 1'b0, 16'hFFE0, 1'b0);
    addv(3, 1'b1, 2,    100,    -50,  0, 1'b0, 16'h0640, 1'b0);
    addv(4, 1'b0, 3,  16383,  16383, 16383, 1'b1, 16'hBFFD, 1'b1);
    addv(5, 1'b1, 2, -16384, -16384,  0, 1'b1, 16'h8000, 1'b0);
    addv(6, 1'b0, 3, -16384, -16384, -1, 1'b1, 16'h7FFF, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {27'd0, req0_ready, req1_ready, res_valid, res_id, res_ovf}, 32'd0);
    chk("reset_data", {16'd0, res_data}, 32'd0);
    chk("reset_tree_in", {31'd0, tree_in == '0}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    pair(1'b0);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].id, tbl[i].k, tbl[i].v[0], tbl[i].v[1], tbl[i].v[2], tbl[i].single, 1'b0, 1'b0, t0);
      get_result(tbl[i].id, tbl[i].exp, tbl[i].ovf, 0, t0, 2 + tbl[i].k, $sformatf("vec%0d", i));
    end

    pair(1'b1);

    send(1'b0, 3, 5, 6, 7, 1'b0, 1'b1, 1'b1, t0);
    get_result(1'b0, 16'd576, 1'b0, 5, t0, 0, "gap_hold");
    wait_ready(1'b1);
    drive(1'b1, '0, 1'b0, 1'b0);
    get_result(1'b1, 16'd128, 1'b0, 0, 0, 0, "after_lock");

    send(1'b0, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, t0);
    get_result(1'b0, 16'd32, 1'b0, 0, t0, 3, "pre_abort");
    drive(1'b1, mk(9, 1'b0), 1'b0, 1'b1);
    wait_ready(1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_result", {29'd0, res_valid, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    pair(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
